stack_engine: RTL and testbench
===============================

// Module: stack_engine
// PURPOSE
//  Sequences PUSH/POP of 16-bit register pairs between the 8-bit register file and memory; owns SP.
//  Reads pairs via the file's two select/output ports; on POP writes back via data_in/data_in_sel/write_reg.
//  Sits beside the register file in the CPU datapath; the decoder drives start/op/pair; memory uses a req/ack handshake.
// PARAMETERS
//  SP_RESET  16'hFFFE  SP value after reset
//  SP_FLOOR  16'hC000  lowest legal stack address (used only when STACK_ENGINE_SP_GUARD_EN is defined)
// PORTS
//  clock          in   1   single clock; all state changes on posedge
//  reset          in   1   synchronous, active-high
//  start          in   1   begin op; sampled only in IDLE
//  op             in   1   0=PUSH, 1=POP
//  pair           in   2   0=BC 1=DE 2=HL 3=AF
//  busy           out  1   high in every state except IDLE
//  done           out  1   1-cycle pulse on the final access's ack
//  sp_load        in   1   load SP from sp_load_val (IDLE only)
//  sp_load_val    in   16  new SP value
//  sp             out  16  current SP
//  rf_out1_sel    out  3   high-byte select (B=0 D=2 H=4 A=7)
//  rf_out2_sel    out  3   low-byte select (C=1 E=3 L=5; 6 for AF, which reads zero)
//  rf_out1        in   8   register-file output 1
//  rf_out2        in   8   register-file output 2
//  rf_data_in     out  8   write-back byte (= mem_rdata)
//  rf_data_in_sel out  3   write-back register index
//  rf_write_reg   out  1   write strobe to register file
//  flags_in       in   4   ZNHC, pushed as {flags_in,4'b0}
//  flags_out      out  4   mem_rdata[7:4] on POP AF
//  flags_load     out  1   1-cycle strobe loading flags_out
//  mem_addr       out  16  access address
//  mem_wdata      out  8   write byte
//  mem_req        out  1   access request; held until ack
//  mem_we         out  1   1=write, 0=read
//  mem_rdata      in   8   read byte, valid with mem_ack
//  mem_ack        in   1   access complete; sampled at posedge while mem_req=1
//  sp_fault       out  1   1-cycle fault pulse (guard feature only)
// BEHAVIOUR
//  Reset: state IDLE; sp=SP_RESET; busy, done, mem_req, mem_we, rf_write_reg, flags_load, sp_fault = 0; selects, data and address = 0.
//  FSM: IDLE -> PUSH_HI -> PUSH_LO -> IDLE | IDLE -> POP_LO -> POP_HI -> IDLE.
//  PUSH_HI: addr=sp-1, wdata=high byte; on ack sp<=sp-1. PUSH_LO: addr=sp-1, wdata=low byte (AF: {flags_in,4'b0}); on ack sp<=sp-1, done.
//  POP_LO: addr=sp, read; on ack sp<=sp+1 and low reg written (AF: flags_load, no rf write). POP_HI: same for high reg; done.
//  rf_write_reg/flags_load are combinational = state is POP_x & mem_ack: zero added latency; written on the ack edge.
//  mem_req/mem_we/mem_addr/mem_wdata stable for the whole state; min 1 cycle per access, op = 2 accesses + waits.
//  Selects are held through both PUSH states; source bytes are sampled on the ack edge.
//  SP arithmetic is 16-bit modulo: 0x0000-1=0xFFFF, 0xFFFF+1=0x0000, no flag.
//  start or sp_load while busy: ignored. start and sp_load in the same IDLE cycle: sp_load wins, start dropped.
//  Reset mid-op: abort to IDLE next edge. Bytes already written stay in memory; registers already written stay; no done.
// CONFIGURATION
//  STACK_ENGINE_SP_GUARD_EN defined:
//  - PUSH with sp-2 < SP_FLOOR (unsigned, incl. wrap) -> no memory access, sp unchanged.
//  - Stays IDLE; sp_fault pulses 1 cycle, done pulses 1 cycle.
//  STACK_ENGINE_SP_GUARD_EN undefined: sp_fault tied 0; every push proceeds; SP_FLOOR unused.
// STRUCTURE
//  stack_engine_pkg: op/pair encodings, FSM state typedef, register index constants (REG_B..REG_A, REG_ZERO=6).
//  Sub-module sp_unit: 16-bit SP register with load/inc/dec and reset to SP_RESET; FSM and muxing stay in stack_engine.
// TESTING
//  1. B=0x12,C=0x34,sp=0xFFFE, PUSH BC, ack every cycle -> writes [0xFFFD]=0x12, [0xFFFC]=0x34; sp=0xFFFC; done in cycle 2.
//  2. [0xFFFC]=0x34,[0xFFFD]=0x12, POP DE -> E=0x34 then D=0x12 (one rf_write_reg each); sp=0xFFFE.
//  3. PUSH AF, A=0xAB, flags_in=4'b1010 -> writes 0xAB then 0xA0; POP AF from 0xA0/0xAB -> flags_out=1010, A=0xAB.
//  4. ack delayed 3 cycles/access; start/sp_load pulsed mid-op -> address and data held stable, both pulses ignored, done after 8 cycles.
//  5. sp=0x0001, PUSH HL -> writes at 0x0000 then 0xFFFF; sp=0xFFFF. Reset asserted during PUSH_LO -> IDLE, sp=0xFFFE, no done.
//  6. Guard build, SP_FLOOR=0xC000, sp=0xC001, PUSH BC -> sp_fault pulse, no mem_req, sp=0xC001; non-guard build: push proceeds.

Source files
------------

// File: rtl/stack_engine_pkg.sv
// stack_engine_pkg: shared encodings for the stack engine.
//   op_e      - PUSH/POP opcode from the decoder
//   pair_e    - register pair selector (BC, DE, HL, AF)
//   state_e   - sequencing FSM states
//   REG_*     - register-file indices; REG_ZERO reads as zero and stands in for F
//   hi_reg / lo_reg - map a pair to its high/low register index
package stack_engine_pkg;

    typedef enum logic {
        OpPush = 1'b0,
        OpPop  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        PairBc = 2'd0,
        PairDe = 2'd1,
        PairHl = 2'd2,
        PairAf = 2'd3
    } pair_e;

    typedef enum logic [2:0] {
        StIdle,
        StPushHi,
        StPushLo,
        StPopLo,
        StPopHi
    } state_e;

    localparam logic [2:0] REG_B    = 3'd0;
    localparam logic [2:0] REG_C    = 3'd1;
    localparam logic [2:0] REG_D    = 3'd2;
    localparam logic [2:0] REG_E    = 3'd3;
    localparam logic [2:0] REG_H    = 3'd4;
    localparam logic [2:0] REG_L    = 3'd5;
    localparam logic [2:0] REG_ZERO = 3'd6;
    localparam logic [2:0] REG_A    = 3'd7;

    function automatic logic [2:0] hi_reg(pair_e p);
        case (p)
            PairBc:  return REG_B;
            PairDe:  return REG_D;
            PairHl:  return REG_H;
            default: return REG_A;
        endcase
    endfunction

    function automatic logic [2:0] lo_reg(pair_e p);
        case (p)
            PairBc:  return REG_C;
            PairDe:  return REG_E;
            PairHl:  return REG_L;
            default: return REG_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/stack_engine_if.sv
// stack_engine_if: memory req/ack bus between the stack engine and memory.
//   mem_addr  - access address          mem_wdata - write byte
//   mem_req   - request, held until ack mem_we    - 1=write, 0=read
//   mem_rdata - read byte, valid w/ ack mem_ack   - access complete at posedge
// Modports: master (stack engine side), slave (memory side).
interface stack_engine_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_engine_sp_unit.sv
// stack_engine_sp_unit: 16-bit stack pointer register.
//   clock, reset - clock and synchronous active-high reset (sp <= SP_RESET)
//   load/load_val - parallel load (highest priority after reset)
//   dec / inc     - modulo-2^16 decrement / increment by one
//   sp            - current stack pointer
module stack_engine_sp_unit #(
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] sp
);

    logic [15:0] sp_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q <= SP_RESET;
        end else if (load) begin
            sp_q <= load_val;
        end else if (dec) begin
            sp_q <= sp_q - 16'd1;
        end else if (inc) begin
            sp_q <= sp_q + 16'd1;
        end
    end

    assign sp = sp_q;

endmodule

// File: rtl/stack_engine.sv
// stack_engine: sequences PUSH/POP of 16-bit register pairs between the 8-bit
// register file and memory, and owns SP.
//   clock, reset        - clock, synchronous active-high reset
//   start, op, pair     - decoder command (sampled in IDLE only)
//   busy, done          - status; done pulses on the final access's ack
//   sp_load/sp_load_val - SP load in IDLE (wins over start); sp - current SP
//   rf_out1/2_sel, rf_out1/2 - register-file read ports (high/low byte)
//   rf_data_in/_sel, rf_write_reg - register-file write-back on POP
//   flags_in/flags_out/flags_load - flag nibble for AF
//   mem                 - memory req/ack bus (stack_engine_if.master)
//   sp_fault            - guard fault pulse
// Build option: STACK_ENGINE_SP_GUARD_EN enables the SP_FLOOR push guard;
// without it sp_fault is tied low and every push proceeds.
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter logic [15:0] SP_RESET = 16'hFFFE
`ifdef STACK_ENGINE_SP_GUARD_EN
    ,
    parameter logic [15:0] SP_FLOOR = 16'hC000
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [1:0]    pair,
    output logic          busy,
    output logic          done,
    input  logic          sp_load,
    input  logic [15:0]   sp_load_val,
    output logic [15:0]   sp,
    output logic [2:0]    rf_out1_sel,
    output logic [2:0]    rf_out2_sel,
    input  logic [7:0]    rf_out1,
    input  logic [7:0]    rf_out2,
    output logic [7:0]    rf_data_in,
    output logic [2:0]    rf_data_in_sel,
    output logic          rf_write_reg,
    input  logic [3:0]    flags_in,
    output logic [3:0]    flags_out,
    output logic          flags_load,
    stack_engine_if.master mem,
    output logic          sp_fault
);

    state_e      state_q, state_d;
    pair_e       pair_q;
    logic        sp_inc, sp_dec, fault;
    logic        start_ok;
    logic        guard_hit;
    logic [15:0] addr_c;
    logic [7:0]  wdata_c;
    logic        req_c, we_c;

    // sp_load takes priority over start in the same IDLE cycle.
    assign start_ok = (state_q == StIdle) && start && !sp_load;

`ifdef STACK_ENGINE_SP_GUARD_EN
    logic [15:0] sp_minus2;
    assign sp_minus2 = sp - 16'd2;
    // sp < 2 means sp-2 wraps below zero: always below the floor.
    assign guard_hit = (sp < 16'd2) || (sp_minus2 < SP_FLOOR);
`else
    assign guard_hit = 1'b0;
`endif

    stack_engine_sp_unit #(
        .SP_RESET (SP_RESET)
    ) u_sp_unit (
        .clock    (clock),
        .reset    (reset),
        .load     ((state_q == StIdle) && sp_load),
        .load_val (sp_load_val),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            pair_q  <= PairBc;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                pair_q <= pair_e'(pair);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sp_inc  = 1'b0;
        sp_dec  = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    if (op == OpPop) begin
                        state_d = StPopLo;
                    end else if (guard_hit) begin
                        fault = 1'b1;
                    end else begin
                        state_d = StPushHi;
                    end
                end
            end
            StPushHi: begin
                if (mem.mem_ack) begin
                    sp_dec  = 1'b1;
                    state_d = StPushLo;
                end
            end
            StPushLo: begin
                if (mem.mem_ack) begin
                    sp_dec  = 1'b1;
                    state_d = StIdle;
                end
            end
            StPopLo: begin
                if (mem.mem_ack) begin
                    sp_inc  = 1'b1;
                    state_d = StPopHi;
                end
            end
            StPopHi: begin
                if (mem.mem_ack) begin
                    sp_inc  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from state and SP only, so they hold for a whole access.
    // Strobes are masked by reset so an abort never commits a write or done.
    always_comb begin
        busy           = (state_q != StIdle);
        done           = 1'b0;
        rf_out1_sel    = 3'd0;
        rf_out2_sel    = 3'd0;
        rf_data_in     = 8'h00;
        rf_data_in_sel = 3'd0;
        rf_write_reg   = 1'b0;
        flags_out      = 4'h0;
        flags_load     = 1'b0;
        addr_c         = 16'h0000;
        wdata_c        = 8'h00;
        req_c          = 1'b0;
        we_c           = 1'b0;
        unique case (state_q)
            StPushHi, StPushLo: begin
                rf_out1_sel = hi_reg(pair_q);
                rf_out2_sel = lo_reg(pair_q);
                req_c       = 1'b1;
                we_c        = 1'b1;
                addr_c      = sp - 16'd1;
                if (state_q == StPushHi) begin
                    wdata_c = rf_out1;
                end else begin
                    wdata_c = (pair_q == PairAf) ? {flags_in, 4'b0000} : rf_out2;
                    done    = mem.mem_ack && !reset;
                end
            end
            StPopLo: begin
                req_c          = 1'b1;
                addr_c         = sp;
                rf_data_in     = mem.mem_rdata;
                rf_data_in_sel = lo_reg(pair_q);
                if (pair_q == PairAf) begin
                    flags_out  = mem.mem_rdata[7:4];
                    flags_load = mem.mem_ack && !reset;
                end else begin
                    rf_write_reg = mem.mem_ack && !reset;
                end
            end
            StPopHi: begin
                req_c          = 1'b1;
                addr_c         = sp;
                rf_data_in     = mem.mem_rdata;
                rf_data_in_sel = hi_reg(pair_q);
                rf_write_reg   = mem.mem_ack && !reset;
                done           = mem.mem_ack && !reset;
            end
            default: begin
                // A guarded push completes immediately from IDLE.
                done = fault && !reset;
            end
        endcase
    end

    assign sp_fault      = fault && !reset;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;
    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: self-checking bench for stack_engine. Provides a register
// file and a memory with programmable ack latency, and compares against a
// pair-level reference model of PUSH/POP.
module tb_stack_engine;
    import stack_engine_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, op = 1'b0;
    logic [1:0]  pair = 2'd0;
    logic        busy, done, sp_load = 1'b0;
    logic [15:0] sp_load_val = 16'h0, sp;
    logic [2:0]  rf_out1_sel, rf_out2_sel, rf_data_in_sel;
    logic [7:0]  rf_out1, rf_out2, rf_data_in;
    logic        rf_write_reg, flags_load, sp_fault;
    logic [3:0]  flags_in = 4'h0, flags_out;

    stack_engine_if mem_bus ();

    stack_engine dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .pair(pair),
        .busy(busy), .done(done), .sp_load(sp_load), .sp_load_val(sp_load_val),
        .sp(sp), .rf_out1_sel(rf_out1_sel), .rf_out2_sel(rf_out2_sel),
        .rf_out1(rf_out1), .rf_out2(rf_out2), .rf_data_in(rf_data_in),
        .rf_data_in_sel(rf_data_in_sel), .rf_write_reg(rf_write_reg),
        .flags_in(flags_in), .flags_out(flags_out), .flags_load(flags_load),
        .mem(mem_bus), .sp_fault(sp_fault)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    // Environment: register file, memory, counters.
    logic [7:0] rf [0:7];
    logic [3:0] flags_reg;
    logic [7:0] mem [0:65535];
    bit         written [0:65535];
    int         ack_delay = 0, wait_cnt = 0;
    int         done_cnt = 0, wr_cnt = 0, rfw_cnt = 0, fault_cnt = 0, req_cycles = 0;
    int         instab_cnt = 0;
    logic       held = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr = 16'h0;
    logic [7:0]  p_wd = 8'h0;
    logic        pl_rf_en = 1'b0;
    logic [2:0]  pl_rf_idx = 3'd0;
    logic [7:0]  pl_rf_val = 8'h0;

    // Power-up memory contents, known to both environment and model.
    function automatic logic [7:0] fill(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(logic [15:0] a);
        return written[a] ? mem[a] : fill(a);
    endfunction

    assign rf_out1 = (rf_out1_sel == 3'd6) ? 8'h00 : rf[rf_out1_sel];
    assign rf_out2 = (rf_out2_sel == 3'd6) ? 8'h00 : rf[rf_out2_sel];
    assign mem_bus.mem_ack   = mem_bus.mem_req && (wait_cnt >= ack_delay);
    assign mem_bus.mem_rdata = mem_bus.mem_req ? env_rd(mem_bus.mem_addr) : 8'h00;

    always @(posedge clock) begin
        if (mem_bus.mem_req && !mem_bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_bus.mem_req && mem_bus.mem_ack && mem_bus.mem_we) begin
            mem[mem_bus.mem_addr]     <= mem_bus.mem_wdata;
            written[mem_bus.mem_addr] <= 1'b1;
            wr_cnt <= wr_cnt + 1;
        end
        if (pl_rf_en) rf[pl_rf_idx] <= pl_rf_val;
        if (rf_write_reg) begin
            rf[rf_data_in_sel] <= rf_data_in;
            rfw_cnt <= rfw_cnt + 1;
        end
        if (reset) flags_reg <= 4'h0;
        else if (flags_load) flags_reg <= flags_out;
        if (done) done_cnt <= done_cnt + 1;
        if (sp_fault) fault_cnt <= fault_cnt + 1;
        if (mem_bus.mem_req) req_cycles <= req_cycles + 1;
        // A waiting access must not change its address, direction or data.
        if (mem_bus.mem_req && !mem_bus.mem_ack) begin
            if (held && (mem_bus.mem_addr !== p_addr || mem_bus.mem_we !== p_we ||
                         (mem_bus.mem_we && mem_bus.mem_wdata !== p_wd)))
                instab_cnt <= instab_cnt + 1;
            held   <= 1'b1;
            p_addr <= mem_bus.mem_addr;
            p_we   <= mem_bus.mem_we;
            p_wd   <= mem_bus.mem_wdata;
        end else begin
            held <= 1'b0;
        end
    end

    // Reference model: whole-pair PUSH/POP on a flat 64 KiB memory.
    logic [7:0]  m_rf [0:7];
    logic [3:0]  m_flags = 4'h0;
    logic [15:0] m_sp = 16'hFFFE;
    logic [7:0]  m_mem [0:65535];
    bit          m_written [0:65535];
    int          hi_tab [4] = '{0, 2, 4, 7};
    int          lo_tab [4] = '{1, 3, 5, 6};

    function automatic logic [7:0] m_rd(logic [15:0] a);
        return m_written[a] ? m_mem[a] : fill(a);
    endfunction

    task automatic model_push(input int p, input logic [3:0] fl);
        logic [7:0] hi, lo;
        hi = m_rf[hi_tab[p]];
        lo = (p == 3) ? {fl, 4'h0} : m_rf[lo_tab[p]];
        m_mem[m_sp - 16'd1] = hi; m_written[m_sp - 16'd1] = 1'b1;
        m_mem[m_sp - 16'd2] = lo; m_written[m_sp - 16'd2] = 1'b1;
        m_sp = m_sp - 16'd2;
    endtask

    task automatic model_pop(input int p);
        logic [7:0] hi, lo;
        lo = m_rd(m_sp);
        hi = m_rd(m_sp + 16'd1);
        if (p == 3) m_flags = lo[7:4];
        else m_rf[lo_tab[p]] = lo;
        m_rf[hi_tab[p]] = hi;
        m_sp = m_sp + 16'd2;
    endtask

    task automatic set_rf(input int idx, input logic [7:0] v);
        pl_rf_en = 1'b1; pl_rf_idx = idx[2:0]; pl_rf_val = v;
        @(negedge clock);
        pl_rf_en = 1'b0;
        m_rf[idx] = (idx == 6) ? 8'h00 : v;
    endtask

    task automatic load_sp(input logic [15:0] v);
        sp_load = 1'b1; sp_load_val = v;
        @(negedge clock);
        sp_load = 1'b0;
        m_sp = v;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_sp = 16'hFFFE; m_flags = 4'h0;
    endtask

    // Issue one op from IDLE at a negedge; returns cycles from start edge to done.
    task automatic do_op(input logic o, input logic [1:0] p, input bit disturb,
                         output int cycles);
        start = 1'b1; op = o; pair = p;
        @(negedge clock);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            if (disturb && cycles == 3) begin
                start = 1'b1; sp_load = 1'b1; sp_load_val = 16'h1234;
            end else begin
                start = 1'b0; sp_load = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        start = 1'b0; sp_load = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL op_timeout got=no_done cycles=%0d required=done", cycles);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 8; i++) set_rf(i, 8'h00);
        checks++; if (sp !== 16'hFFFE) begin failures++; $display("FAIL reset_sp got=%h exp=fffe", sp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_bus.mem_addr); end
        checks++; if ({rf_write_reg, flags_load, sp_fault, mem_bus.mem_we} !== 4'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0000", {rf_write_reg, flags_load, sp_fault, mem_bus.mem_we}); end
    endtask

    task automatic test_push_bc();
        int cyc, d0, w0;
        set_rf(0, 8'h12); set_rf(1, 8'h34);
        ack_delay = 0; d0 = done_cnt; w0 = wr_cnt;
        model_push(0, flags_in);
        do_op(1'b0, 2'd0, 1'b0, cyc);
        checks++; if (cyc != 2) begin failures++; $display("FAIL push_bc_latency got=%0d exp=2", cyc); end
        checks++; if (env_rd(16'hFFFD) !== 8'h12) begin failures++; $display("FAIL push_bc_hi got=%h exp=12", env_rd(16'hFFFD)); end
        checks++; if (env_rd(16'hFFFC) !== 8'h34) begin failures++; $display("FAIL push_bc_lo got=%h exp=34", env_rd(16'hFFFC)); end
        checks++; if (sp !== 16'hFFFC) begin failures++; $display("FAIL push_bc_sp got=%h exp=fffc", sp); end
        checks++; if (done_cnt - d0 != 1 || wr_cnt - w0 != 2) begin
            failures++; $display("FAIL push_bc_counts done=%0d writes=%0d exp=1,2", done_cnt - d0, wr_cnt - w0); end
    endtask

    task automatic test_pop_de();
        int cyc, r0;
        r0 = rfw_cnt;
        model_pop(1);
        do_op(1'b1, 2'd1, 1'b0, cyc);
        checks++; if (rf[3] !== 8'h34) begin failures++; $display("FAIL pop_de_e got=%h exp=34", rf[3]); end
        checks++; if (rf[2] !== 8'h12) begin failures++; $display("FAIL pop_de_d got=%h exp=12", rf[2]); end
        checks++; if (sp !== 16'hFFFE) begin failures++; $display("FAIL pop_de_sp got=%h exp=fffe", sp); end
        checks++; if (rfw_cnt - r0 != 2) begin failures++; $display("FAIL pop_de_writes got=%0d exp=2", rfw_cnt - r0); end
    endtask

    task automatic test_af();
        int cyc, r0;
        set_rf(7, 8'hAB); flags_in = 4'b1010;
        model_push(3, flags_in);
        do_op(1'b0, 2'd3, 1'b0, cyc);
        checks++; if (env_rd(16'hFFFD) !== 8'hAB) begin failures++; $display("FAIL push_af_hi got=%h exp=ab", env_rd(16'hFFFD)); end
        checks++; if (env_rd(16'hFFFC) !== 8'hA0) begin failures++; $display("FAIL push_af_lo got=%h exp=a0", env_rd(16'hFFFC)); end
        set_rf(7, 8'h00); flags_in = 4'h0; r0 = rfw_cnt;
        model_pop(3);
        do_op(1'b1, 2'd3, 1'b0, cyc);
        checks++; if (flags_reg !== 4'b1010) begin failures++; $display("FAIL pop_af_flags got=%b exp=1010", flags_reg); end
        checks++; if (rf[7] !== 8'hAB) begin failures++; $display("FAIL pop_af_a got=%h exp=ab", rf[7]); end
        checks++; if (rfw_cnt - r0 != 1) begin failures++; $display("FAIL pop_af_writes got=%0d exp=1", rfw_cnt - r0); end
    endtask

    task automatic test_stall_disturb();
        int cyc, d0, q0;
        set_rf(4, 8'h5C); set_rf(5, 8'hE7);
        ack_delay = 3; d0 = done_cnt; q0 = req_cycles;
        model_push(2, flags_in);
        do_op(1'b0, 2'd2, 1'b1, cyc);
        checks++; if (cyc != 8) begin failures++; $display("FAIL stall_latency got=%0d exp=8", cyc); end
        checks++; if (instab_cnt != 0) begin failures++; $display("FAIL stall_stable got=%0d changes exp=0", instab_cnt); end
        checks++; if (sp !== m_sp) begin failures++; $display("FAIL stall_sp got=%h exp=%h", sp, m_sp); end
        checks++; if (env_rd(16'hFFFD) !== 8'h5C || env_rd(16'hFFFC) !== 8'hE7) begin
            failures++; $display("FAIL stall_data got=%h%h exp=5ce7", env_rd(16'hFFFD), env_rd(16'hFFFC)); end
        checks++; if (busy !== 1'b0 || done_cnt - d0 != 1 || req_cycles - q0 != 8) begin
            failures++; $display("FAIL stall_ignored busy=%b done=%0d req=%0d exp=0,1,8", busy, done_cnt - d0, req_cycles - q0); end
        ack_delay = 0;
    endtask

    task automatic test_load_priority();
        start = 1'b1; op = 1'b0; pair = 2'd0; sp_load = 1'b1; sp_load_val = 16'h0001;
        @(negedge clock);
        start = 1'b0; sp_load = 1'b0; m_sp = 16'h0001;
        checks++; if (sp !== 16'h0001 || busy !== 1'b0) begin
            failures++; $display("FAIL load_wins got sp=%h busy=%b exp=0001,0", sp, busy); end
    endtask

    task automatic test_wrap();
        int cyc;
        set_rf(4, 8'h9E); set_rf(5, 8'h61);
        model_push(2, flags_in);
        do_op(1'b0, 2'd2, 1'b0, cyc);
        checks++; if (env_rd(16'h0000) !== 8'h9E || env_rd(16'hFFFF) !== 8'h61) begin
            failures++; $display("FAIL wrap_push got=%h,%h exp=9e,61", env_rd(16'h0000), env_rd(16'hFFFF)); end
        checks++; if (sp !== 16'hFFFF) begin failures++; $display("FAIL wrap_push_sp got=%h exp=ffff", sp); end
        set_rf(4, 8'h00); set_rf(5, 8'h00);
        model_pop(2);
        do_op(1'b1, 2'd2, 1'b0, cyc);
        checks++; if (sp !== 16'h0001 || rf[4] !== 8'h9E || rf[5] !== 8'h61) begin
            failures++; $display("FAIL wrap_pop got sp=%h h=%h l=%h exp=0001,9e,61", sp, rf[4], rf[5]); end
    endtask

    task automatic test_reset_mid_op();
        int d0, w0;
        set_rf(0, 8'h3C); set_rf(1, 8'hC3);
        ack_delay = 3; d0 = done_cnt; w0 = wr_cnt;
        start = 1'b1; op = 1'b0; pair = 2'd0;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);  // now in the second access, still waiting
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || sp !== 16'hFFFE) begin
            failures++; $display("FAIL abort_state got busy=%b sp=%h exp=0,fffe", busy, sp); end
        checks++; if (done_cnt != d0 || wr_cnt - w0 != 1 || env_rd(16'h0000) !== 8'h3C) begin
            failures++; $display("FAIL abort_effects done=%0d writes=%0d mem=%h exp=0,1,3c",
                                 done_cnt - d0, wr_cnt - w0, env_rd(16'h0000)); end
        m_mem[16'h0000] = 8'h3C; m_written[16'h0000] = 1'b1;
        m_sp = 16'hFFFE; m_flags = 4'h0; ack_delay = 0;
    endtask

    task automatic test_guard();
        int f0, q0, cyc;
        load_sp(16'hC001);
        f0 = fault_cnt; q0 = req_cycles;
`ifdef STACK_ENGINE_SP_GUARD_EN
        start = 1'b1; op = 1'b0; pair = 2'd0;
        #1;
        checks++; if (sp_fault !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL guard_pulse got fault=%b done=%b exp=1,1", sp_fault, done); end
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++; if (sp !== 16'hC001 || busy !== 1'b0 || req_cycles != q0 || fault_cnt - f0 != 1) begin
            failures++; $display("FAIL guard_block got sp=%h busy=%b req=%0d faults=%0d exp=c001,0,0,1",
                                 sp, busy, req_cycles - q0, fault_cnt - f0); end
`else
        model_push(0, flags_in);
        do_op(1'b0, 2'd0, 1'b0, cyc);
        checks++; if (sp !== 16'hBFFF || fault_cnt != f0 || req_cycles - q0 != 2) begin
            failures++; $display("FAIL noguard_push got sp=%h faults=%0d req=%0d exp=bfff,0,2",
                                 sp, fault_cnt - f0, req_cycles - q0); end
`endif
    endtask

    task automatic test_random();
        int cyc, p;
        logic o;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) load_sp(16'($urandom));
            if ($urandom_range(0, 1) == 0) set_rf($urandom_range(0, 7), 8'($urandom));
            o = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 3);
            ack_delay = $urandom_range(0, 2);
            flags_in = 4'($urandom);
`ifdef STACK_ENGINE_SP_GUARD_EN
            if (!o && (m_sp < 16'd2 || (m_sp - 16'd2) < 16'hC000)) o = 1'b1;
`endif
            a = m_sp;
            if (o) model_pop(p);
            else model_push(p, flags_in);
            do_op(o, p[1:0], 1'b0, cyc);
            checks++; if (sp !== m_sp) begin failures++; $display("FAIL rand_sp[%0d] got=%h exp=%h", i, sp, m_sp); end
            for (int r = 0; r < 8; r++) begin
                if (r != 6) begin
                    checks++; if (rf[r] !== m_rf[r]) begin
                        failures++; $display("FAIL rand_reg[%0d] r%0d got=%h exp=%h", i, r, rf[r], m_rf[r]); end
                end
            end
            checks++; if (flags_reg !== m_flags) begin
                failures++; $display("FAIL rand_flags[%0d] got=%h exp=%h", i, flags_reg, m_flags); end
            if (!o) begin
                checks++; if (env_rd(a - 16'd1) !== m_rd(a - 16'd1) || env_rd(a - 16'd2) !== m_rd(a - 16'd2)) begin
                    failures++; $display("FAIL rand_mem[%0d] got=%h%h exp=%h%h", i, env_rd(a - 16'd1),
                                         env_rd(a - 16'd2), m_rd(a - 16'd1), m_rd(a - 16'd2)); end
            end
        end
        ack_delay = 0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_push_bc();
        test_pop_de();
        test_af();
        test_stall_disturb();
        test_load_priority();
        test_wrap();
        test_reset_mid_op();
        test_guard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
